// File: rtl/pwm_pkg.sv
// Shared definitions for the keyboard-driven multi-channel PWM controller:
// PS/2 set-2 key codes, decoder state encoding and preset duty formula.
package pwm_pkg;

   localparam logic [7:0] SC_BRK = 8'hF0;
   localparam logic [7:0] SC_EXT = 8'hE0;
   localparam logic [7:0] SC_K1  = 8'h16;
   localparam logic [7:0] SC_K2  = 8'h1E;
   localparam logic [7:0] SC_K3  = 8'h26;
   localparam logic [7:0] SC_K4  = 8'h25;
   localparam logic [7:0] SC_UP  = 8'h3C;
   localparam logic [7:0] SC_DN  = 8'h23;
   localparam logic [7:0] SC_F   = 8'h2B;
   localparam logic [7:0] SC_Q   = 8'h15;
   localparam logic [7:0] SC_H   = 8'h33;
   localparam logic [7:0] SC_X   = 8'h22;
   localparam logic [7:0] SC_Z   = 8'h1A;
   localparam logic [7:0] SC_A   = 8'h1C;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BRK  = 2'd1,
      ST_EXT  = 2'd2
   } dec_state_t;

   // Preset duty as quarters of the frame; truncating integer division.
   function automatic int preset_duty(input int period, input int quarters);
      return (period * quarters) / 4;
   endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Divides clkdiv4 into a one-cycle step enable every PRESC cycles.
module pwm_prescaler
   import pwm_pkg::*;
#(
   parameter int PRESC = 625
) (
   input  logic clkdiv4,
   input  logic reset,
   output logic en_out
);

   localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESC - 1);

   logic [PW-1:0] cnt_r;
   logic [PW-1:0] nxt_s;
   logic          en_r;

   // Next prescaler value, wrapping after the last state.
   always_comb begin
      if (cnt_r == LAST) begin
         nxt_s = '0;
      end else begin
         nxt_s = cnt_r + PW'(1);
      end
   end

   // The enable is registered against the next count so it is high exactly
   // while the counter sits on its last state.
   always_ff @(posedge clkdiv4) begin
      if (reset) begin
         cnt_r <= '0;
         en_r  <= (LAST == '0);
      end else begin
         cnt_r <= nxt_s;
         en_r  <= (nxt_s == LAST);
      end
   end

   assign en_out = en_r;

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM generator whose duties are edited through PS/2 key codes;
// edits land in shadow registers and reach the outputs only at frame wrap.
module pwm_multi_ctrl
   import pwm_pkg::*;
#(
   parameter int NCH       = 4,
   parameter int CW        = 10,
   parameter int PERIOD    = 800,
   parameter int PRESC     = 625,
   parameter int STEP      = 10,
   parameter int DUTY_INIT = 41
) (
   input  logic           clkdiv4,
   input  logic           reset,
   input  logic           scan_valid,
   input  logic [7:0]     scancode,
   output logic [NCH-1:0] pwm,
   output logic [2:0]     sel_ch,
   output logic           frame_tick
);

   localparam logic [CW-1:0] DUTY_INIT_W = CW'(DUTY_INIT);
   localparam logic [CW-1:0] LAST_CNT    = CW'(PERIOD - 1);
   localparam logic [CW:0]   STEP_W      = (CW + 1)'(STEP);
   localparam logic [CW:0]   PERIOD_W    = (CW + 1)'(PERIOD);
   localparam logic [CW-1:0] DUTY_F      = CW'(preset_duty(PERIOD, 1));
   localparam logic [CW-1:0] DUTY_Q      = CW'(preset_duty(PERIOD, 2));
   localparam logic [CW-1:0] DUTY_H      = CW'(preset_duty(PERIOD, 3));
   localparam logic [CW-1:0] DUTY_X      = CW'(preset_duty(PERIOD, 4));

   logic                     step_en_s;
   logic                     wrap_s;
   logic [CW-1:0]            cnt_r;
   logic                     frame_tick_r;
   dec_state_t               state_r;
   logic [2:0]               sel_r;
   logic [NCH-1:0][CW-1:0]   duty_sh_r;
   logic [NCH-1:0][CW-1:0]   sh_nx_s;
   logic [CW-1:0]            cur_s;
   logic [CW:0]              up_s;
   logic [CW:0]              dn_s;
   logic [2:0]               sel_nx_s;
   logic                     wr_one_s;
   logic                     wr_all_s;
   logic [CW-1:0]            wr_val_s;

   pwm_prescaler #(.PRESC(PRESC)) u_presc (
      .clkdiv4 (clkdiv4),
      .reset   (reset),
      .en_out  (step_en_s)
   );

   assign wrap_s = step_en_s && (cnt_r == LAST_CNT);

   // Frame counter and the wrap pulse.
   always_ff @(posedge clkdiv4) begin
      if (reset) begin
         cnt_r        <= '0;
         frame_tick_r <= 1'b0;
      end else begin
         if (step_en_s) begin
            cnt_r <= wrap_s ? '0 : cnt_r + CW'(1);
         end else begin
            cnt_r <= cnt_r;
         end
         frame_tick_r <= wrap_s;
      end
   end

   // Key action decode; only bytes arriving in IDLE carry an action.
   always_comb begin
      cur_s = '0;
      for (int i = 0; i < NCH; i++) begin
         cur_s = (sel_r == 3'(i)) ? duty_sh_r[i] : cur_s;
      end
      up_s     = {1'b0, cur_s} + STEP_W;
      dn_s     = {1'b0, cur_s} - STEP_W;
      sel_nx_s = sel_r;
      wr_one_s = 1'b0;
      wr_all_s = 1'b0;
      wr_val_s = cur_s;
      if (scan_valid && (state_r == ST_IDLE)) begin
         case (scancode)
            SC_K1: sel_nx_s = 3'd0;
            SC_K2: sel_nx_s = (NCH > 1) ? 3'd1 : sel_r;
            SC_K3: sel_nx_s = (NCH > 2) ? 3'd2 : sel_r;
            SC_K4: sel_nx_s = (NCH > 3) ? 3'd3 : sel_r;
            SC_UP: begin
               wr_one_s = 1'b1;
               wr_val_s = (up_s > PERIOD_W) ? PERIOD_W[CW-1:0] : up_s[CW-1:0];
            end
            SC_DN: begin
               // A borrow out of the CW+1 bit difference means we went below zero.
               wr_one_s = 1'b1;
               wr_val_s = dn_s[CW] ? '0 : dn_s[CW-1:0];
            end
            SC_F: begin
               wr_one_s = 1'b1;
               wr_val_s = DUTY_F;
            end
            SC_Q: begin
               wr_one_s = 1'b1;
               wr_val_s = DUTY_Q;
            end
            SC_H: begin
               wr_one_s = 1'b1;
               wr_val_s = DUTY_H;
            end
            SC_X: begin
               wr_one_s = 1'b1;
               wr_val_s = DUTY_X;
            end
            SC_Z: begin
               wr_one_s = 1'b1;
               wr_val_s = '0;
            end
            SC_A: wr_all_s = 1'b1;
            default: sel_nx_s = sel_r;
         endcase
      end else begin
         wr_one_s = 1'b0;
      end
   end

   // Post-write shadow values; the active duties load these at wrap.
   always_comb begin
      sh_nx_s = duty_sh_r;
      for (int i = 0; i < NCH; i++) begin
         if (wr_all_s) begin
            sh_nx_s[i] = cur_s;
         end else if (wr_one_s && (sel_r == 3'(i))) begin
            sh_nx_s[i] = wr_val_s;
         end else begin
            sh_nx_s[i] = duty_sh_r[i];
         end
      end
   end

   // Scan-code decoder state, selected channel and shadow duties.
   always_ff @(posedge clkdiv4) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         sel_r     <= 3'd0;
         duty_sh_r <= {NCH{DUTY_INIT_W}};
      end else begin
         if (scan_valid) begin
            case (state_r)
               ST_IDLE: begin
                  if (scancode == SC_BRK) begin
                     state_r <= ST_BRK;
                  end else if (scancode == SC_EXT) begin
                     state_r <= ST_EXT;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end
               ST_BRK:  state_r <= ST_IDLE;
               ST_EXT:  state_r <= (scancode == SC_BRK) ? ST_BRK : ST_IDLE;
               default: state_r <= ST_IDLE;
            endcase
         end else begin
            state_r <= state_r;
         end
         sel_r     <= sel_nx_s;
         duty_sh_r <= sh_nx_s;
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [CW-1:0] duty_act_r;
      logic          pwm_bit_r;

      // Active duty changes only at wrap, so a frame never sees a partial edit.
      always_ff @(posedge clkdiv4) begin
         if (reset) begin
            duty_act_r <= DUTY_INIT_W;
            pwm_bit_r  <= 1'b0;
         end else begin
            if (wrap_s) begin
               duty_act_r <= sh_nx_s[g];
            end else begin
               duty_act_r <= duty_act_r;
            end
            pwm_bit_r <= (cnt_r < duty_act_r);
         end
      end

      assign pwm[g] = pwm_bit_r;
   end

   assign sel_ch     = sel_r;
   assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Directed bench for pwm_multi_ctrl: 10-step frames with one step per clock,
// keys injected at chosen counter positions, whole-frame pwm patterns compared.
module tb_pwm_multi_ctrl;

   localparam int NCH = 4;

   logic           clkdiv4 = 1'b0;
   logic           reset;
   logic           scan_valid;
   logic [7:0]     scancode;
   logic [NCH-1:0] pwm;
   logic [2:0]     sel_ch;
   logic           frame_tick;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] kv [10];

   always #5 clkdiv4 = ~clkdiv4;

   pwm_multi_ctrl #(
      .NCH(NCH), .CW(10), .PERIOD(10), .PRESC(1), .STEP(2), .DUTY_INIT(3)
   ) dut (
      .clkdiv4    (clkdiv4),
      .reset      (reset),
      .scan_valid (scan_valid),
      .scancode   (scancode),
      .pwm        (pwm),
      .sel_ch     (sel_ch),
      .frame_tick (frame_tick)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clkdiv4);
      #1;
   endtask

   task automatic clr_keys();
      for (int i = 0; i < 10; i++) kv[i] = 8'h00;
   endtask

   // Runs one frame from cnt=0, pressing kv[j] while cnt=j; exp_d holds the
   // duty each channel must show in this frame, ordered {ch3,ch2,ch1,ch0}.
   task automatic run_frame(input string tag, input logic [3:0][3:0] exp_d);
      logic [9:0] pat [NCH];
      logic [9:0] ftp;
      logic [9:0] want;
      ftp = '0;
      for (int c = 0; c < NCH; c++) pat[c] = '0;
      for (int j = 0; j < 10; j++) begin
         scan_valid = (kv[j] != 8'h00);
         scancode   = kv[j];
         tick();
         scan_valid = 1'b0;
         scancode   = 8'h00;
         for (int c = 0; c < NCH; c++) pat[c][j] = pwm[c];
         ftp[j] = frame_tick;
      end
      chk($sformatf("%s frame_tick", tag), 32'(ftp), 32'h200);
      for (int c = 0; c < NCH; c++) begin
         want = '0;
         for (int j = 0; j < 10; j++) want[j] = (j < int'(exp_d[c]));
         chk($sformatf("%s pwm%0d", tag, c), 32'(pat[c]), 32'(want));
      end
      clr_keys();
   endtask

   initial begin
      reset      = 1'b1;
      scan_valid = 1'b0;
      scancode   = 8'h00;
      clr_keys();
      repeat (3) tick();
      chk("rst pwm", 32'(pwm), 32'h0);
      chk("rst sel", 32'(sel_ch), 32'h0);
      chk("rst tick", 32'(frame_tick), 32'h0);
      reset = 1'b0;

      run_frame("idle0", {4'd3, 4'd3, 4'd3, 4'd3});
      run_frame("idle1", {4'd3, 4'd3, 4'd3, 4'd3});

      kv[4] = 8'h26; kv[5] = 8'h3C;
      run_frame("sel2", {4'd3, 4'd3, 4'd3, 4'd3});
      chk("sel2 sel", 32'(sel_ch), 32'd2);
      run_frame("up2", {4'd3, 4'd5, 4'd3, 4'd3});

      kv[0] = 8'h16;
      for (int j = 1; j <= 6; j++) kv[j] = 8'h3C;
      run_frame("sat", {4'd3, 4'd5, 4'd3, 4'd3});
      chk("sat sel", 32'(sel_ch), 32'd0);
      kv[2] = 8'h1A;
      run_frame("full", {4'd3, 4'd5, 4'd3, 4'd10});
      run_frame("zero", {4'd3, 4'd5, 4'd3, 4'd0});

      kv[0] = 8'hF0; kv[1] = 8'h3C; kv[2] = 8'hE0; kv[3] = 8'hF0; kv[4] = 8'h23;
      kv[6] = 8'h3C;
      run_frame("brk", {4'd3, 4'd5, 4'd3, 4'd0});
      run_frame("idle_ok", {4'd3, 4'd5, 4'd3, 4'd2});

      kv[0] = 8'h1E; kv[1] = 8'h2B; kv[2] = 8'h1C; kv[9] = 8'h3C;
      run_frame("all", {4'd3, 4'd5, 4'd3, 4'd2});
      chk("all sel", 32'(sel_ch), 32'd1);

      kv[0] = 8'h15; kv[1] = 8'h25; kv[2] = 8'h33; kv[3] = 8'h26; kv[4] = 8'h22;
      kv[5] = 8'h16; kv[6] = 8'h23; kv[7] = 8'h23; kv[8] = 8'h77;
      run_frame("wrapwr", {4'd2, 4'd2, 4'd4, 4'd2});
      chk("wrapwr sel", 32'(sel_ch), 32'd0);

      kv[0] = 8'h25; kv[1] = 8'h23;
      run_frame("presets", {4'd7, 4'd10, 4'd5, 4'd0});
      chk("presets sel", 32'(sel_ch), 32'd3);
      run_frame("down", {4'd5, 4'd10, 4'd5, 4'd0});

      // Enter BRK at cnt=6, then reset at cnt=7 with a key also pending.
      repeat (6) tick();
      scan_valid = 1'b1; scancode = 8'hF0;
      tick();
      reset = 1'b1; scancode = 8'h3C;
      tick();
      scan_valid = 1'b0; scancode = 8'h00;
      chk("midrst pwm", 32'(pwm), 32'h0);
      chk("midrst sel", 32'(sel_ch), 32'h0);
      chk("midrst tick", 32'(frame_tick), 32'h0);
      reset = 1'b0;

      kv[0] = 8'h3C;
      run_frame("post_rst", {4'd3, 4'd3, 4'd3, 4'd3});
      run_frame("post_up", {4'd3, 4'd3, 4'd3, 4'd5});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_multi_ctrl.md
PWM_MULTI_CTRL -- requirements
Module: pwm_multi_ctrl

Interface
REQ-001 Parameter NCH, default 4: number of independent PWM channels, 1..8.
REQ-002 Parameter CW, default 10: width of the period counter and duty values.
REQ-003 Parameter PERIOD, default 800: counter states per PWM frame; SHALL satisfy 2 <= PERIOD <= 2^CW-1.
REQ-004 Parameter PRESC, default 625: clkdiv4 cycles per counter step, >= 1.
REQ-005 Parameter STEP, default 10: duty increment/decrement per key press.
REQ-006 Parameter DUTY_INIT, default 41: duty of every channel after reset, <= PERIOD.
REQ-007 clkdiv4  in  1  sole clock; all logic on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 scan_valid  in  1  one-cycle strobe; scancode is valid when high.
REQ-010 scancode  in  8  PS/2 set-2 byte.
REQ-011 pwm  out  NCH  registered PWM outputs, one bit per channel.
REQ-012 sel_ch  out  3  currently selected channel index.
REQ-013 frame_tick  out  1  one-cycle pulse on every frame wrap.

Function
REQ-014 Prescaler counts 0..PRESC-1; step enable is high in the cycle the prescaler equals PRESC-1, then it wraps to 0.
REQ-015 Frame counter cnt counts 0..PERIOD-1 on step enable, wrapping to 0; frame_tick is high in the cycle cnt wraps.
REQ-016 Each cycle pwm[i] is registered as (cnt < duty_act[i]); the 1-cycle latency is fixed; duty 0 gives constant 0, duty PERIOD gives constant 1.
REQ-017 Key writes update shadow duty_sh[i] only; duty_act[i] loads duty_sh[i] only on frame wrap, so each frame is glitch-free.
REQ-018 A shadow write in the same cycle as a frame wrap takes effect in the new frame, because duty_act loads the post-write shadow value.
REQ-019 Decoder FSM states: IDLE, BRK (after F0), EXT (after E0); it transitions only on scan_valid.
REQ-020 IDLE: F0 -> BRK; E0 -> EXT; any other byte executes its key action and stays in IDLE.
REQ-021 BRK: next byte is discarded, no action -> IDLE.
REQ-022 EXT: next byte F0 -> BRK; any other byte is discarded -> IDLE.
REQ-023 Keys 16/1E/26/25 ('1'-'4') set sel_ch to 0-3; an index >= NCH is ignored.
REQ-024 Key 3C ('U') sets duty_sh[sel] to min(duty_sh+STEP, PERIOD); key 23 ('D') sets it to max(duty_sh-STEP, 0); no wrap, computed at CW+1 bits.
REQ-025 Presets on selected channel: 2B ('F') PERIOD/4, 15 ('Q') PERIOD/2, 33 ('H') 3*PERIOD/4, 22 ('X') PERIOD, 1A ('Z') 0; integer division truncates.
REQ-026 Key 1C ('A') copies duty_sh[sel] to every channel's shadow.
REQ-027 Unlisted bytes in IDLE are ignored; the shadow registers hold their value.

Reset
REQ-028 On reset: prescaler, cnt, sel_ch, frame_tick and pwm are 0; FSM is IDLE; duty_sh and duty_act are DUTY_INIT for all channels.
REQ-029 Reset mid-frame or mid-sequence (BRK/EXT) takes priority over every other event in that cycle; a pending shadow write is lost.

Structure
REQ-030 Shared include pwm_pkg holds scancode constants, FSM state encodings and the preset formulas.
REQ-031 Sub-module pwm_prescaler(clkdiv4, reset, en_out) parametrised by PRESC; channel compare logic is a generate loop.

Verification (NCH=4, PERIOD=10, PRESC=1, STEP=2, DUTY_INIT=3)
REQ-032 Release reset, no keys -> every pwm bit high for exactly 3 of each 10-cycle frame; frame_tick every 10 cycles.
REQ-033 Press 26 then 3C at cnt=5 -> sel_ch=2; pwm[2] stays at 3/10 for the current frame, then 5/10 from the next frame; other channels unchanged.
REQ-034 Six presses of 3C on channel 0 -> duty saturates at 10 (pwm[0] constantly 1); then 1A -> 0 after wrap (constantly 0).
REQ-035 Send F0,3C then E0,F0,23 -> no duty change; FSM returns to IDLE.
REQ-036 Press 2B then 1C -> all channels duty 2 after the next wrap; a 3C write in the wrap cycle is visible in that new frame.
REQ-037 Assert reset during BRK at cnt=7 -> next cycle cnt=0, pwm=0, FSM IDLE, duties back to 3.
